// File: rtl/sum_unit_pkg.sv
// sum_unit_pkg: shared state encoding and default width for the array-sum kernel
package sum_unit_pkg;
  localparam int DEF_WIDTH = 32;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACCUM, WRITE_WAIT, WRITE} state_t;
endpackage

// File: rtl/sum_unit.sv
// sum_unit: sums a signed array over RAM port B and writes the total into a FIFO channel
module sum_unit
  import sum_unit_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sum_req,
  output logic                    sum_busy,
  output logic        [WIDTH-1:0] sum_c_din,
  input  logic        [WIDTH-1:0] sum_c_dout,
  output logic                    sum_c_we,
  output logic                    sum_c_oe,
  input  logic                    sum_c_empty,
  input  logic                    sum_c_full,
  input  logic signed [31:0]      sum_s_length,
  output logic signed [31:0]      sum_s_address_b,
  output logic        [WIDTH-1:0] sum_s_din_b,
  input  logic        [WIDTH-1:0] sum_s_dout_b,
  output logic                    sum_s_we_b,
  output logic                    sum_s_oe_b
);
  state_t state, state_n;
  logic signed [31:0] n, i, addr_q;
  logic [WIDTH-1:0] acc;
  logic [15:0] cnt;
  logic issue;
  logic unused_ok;
  assign unused_ok = ^{sum_c_dout, sum_c_empty};
  assign issue = (state == ISSUE) && (i < n);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      n      <= '0;
      i      <= '0;
      addr_q <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && sum_req) begin
        n   <= sum_s_length;
        i   <= '0;
        acc <= '0;
      end
      if (issue) begin
        addr_q <= i;
        cnt    <= 16'(RD_LATENCY);
      end
      if (state == WAIT) cnt <= cnt - 16'd1;
      if (state == ACCUM) begin
        acc <= acc + sum_s_dout_b;
        i   <= i + 1;
      end
    end
  end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:       state_n = sum_req ? ISSUE : IDLE;
      ISSUE:      state_n = issue ? WAIT : WRITE_WAIT;
      WAIT:       state_n = (cnt == 16'd1) ? ACCUM : WAIT;
      ACCUM:      state_n = ISSUE;
      WRITE_WAIT: state_n = sum_c_full ? WRITE_WAIT : WRITE;
      WRITE:      state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end
  // address is live in ISSUE and then held by addr_q until the next element
  assign sum_s_address_b = issue ? i : addr_q;
  assign sum_s_oe_b      = issue || (state == WAIT);
  assign sum_s_we_b      = 1'b0;
  assign sum_s_din_b     = '0;
  assign sum_c_we        = (state == WRITE);
  assign sum_c_din       = (state == WRITE) ? acc : '0;
  assign sum_c_oe        = 1'b0;
  assign sum_busy        = (state != IDLE);
endmodule

// File: tb/tb_sum_unit.sv
// tb_sum_unit: scoreboard bench for sum_unit with a 1-cycle RAM model and a controllable full flag
module tb_sum_unit;
  logic clk = 0, reset, sum_req, sum_busy, sum_c_we, sum_c_oe, sum_c_empty, sum_c_full, sum_s_we_b, sum_s_oe_b;
  logic [31:0] sum_c_din, sum_c_dout, sum_s_din_b, sum_s_dout_b;
  logic signed [31:0] sum_s_length, sum_s_address_b;
  logic [31:0] mem [64];
  logic [31:0] sb [$];
  int checks = 0, errors = 0, writes = 0, reads = 0, stray = 0, exp_addr = 0;
  logic oe_prev = 0;

  always #5 clk = ~clk;

  sum_unit dut (
    .clk(clk), .reset(reset), .sum_req(sum_req), .sum_busy(sum_busy),
    .sum_c_din(sum_c_din), .sum_c_dout(sum_c_dout), .sum_c_we(sum_c_we), .sum_c_oe(sum_c_oe),
    .sum_c_empty(sum_c_empty), .sum_c_full(sum_c_full), .sum_s_length(sum_s_length),
    .sum_s_address_b(sum_s_address_b), .sum_s_din_b(sum_s_din_b), .sum_s_dout_b(sum_s_dout_b),
    .sum_s_we_b(sum_s_we_b), .sum_s_oe_b(sum_s_oe_b)
  );

  always @(posedge clk) if (sum_s_oe_b) sum_s_dout_b <= mem[sum_s_address_b[5:0]];

  always @(negedge clk) begin
    if (!reset || (sum_req && !sum_busy)) begin
      exp_addr = 0;
      reads = 0;
    end
    if (sum_s_we_b || sum_c_oe || sum_s_din_b != 0 || (!sum_c_we && sum_c_din != 0)) stray++;
    if (sum_s_oe_b && !oe_prev) begin
      checks++;
      if (sum_s_address_b !== exp_addr) begin
        errors++;
        $display("FAIL read_addr: got %0d expected %0d", sum_s_address_b, exp_addr);
      end
      exp_addr++;
      reads++;
    end
    oe_prev = sum_s_oe_b;
    if (sum_c_we) begin
      writes++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL result: unexpected write of %h", sum_c_din);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (sum_c_din !== e) begin
          errors++;
          $display("FAIL result: got %h expected %h", sum_c_din, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_req(input int len);
    sum_s_length = len;
    sum_req = 1;
    @(posedge clk);
    #1 sum_req = 0;
    sum_s_length = 40;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (sum_busy && k < 1000) begin
      @(posedge clk);
      #1 k++;
    end
    chk("idle_timeout", sum_busy, 0);
  endtask

  task automatic run(input int len, input logic [31:0] res, input int nreads);
    sb.push_back(res);
    pulse_req(len);
    chk("busy_start", sum_busy, 1);
    wait_idle();
    chk("read_count", reads, nreads);
  endtask

  initial begin
    int w0;
    reset = 0; sum_req = 0; sum_s_length = 0; sum_c_full = 0; sum_c_dout = 0; sum_c_empty = 1;
    for (int k = 0; k < 64; k++) mem[k] = k;
    repeat (5) @(posedge clk);
    #1 chk("rst_busy", sum_busy, 0);
    chk("rst_outs", {sum_c_we, sum_s_oe_b, sum_s_we_b, sum_c_oe}, 0);
    chk("rst_addr", sum_s_address_b, 0);
    reset = 1;
    repeat (3) @(posedge clk);
    #1 chk("idle_busy", sum_busy, 0);
    chk("idle_din", sum_c_din, 0);
    run(16, 120, 16);
    run(0, 0, 0);
    run(-3, 0, 0);
    sum_c_full = 1;
    sb.push_back(120);
    w0 = writes;
    pulse_req(16);
    repeat (60) @(posedge clk);
    #1 chk("bp_busy", sum_busy, 1);
    chk("bp_no_write", writes, w0);
    sum_c_full = 0;
    @(posedge clk);
    #1 chk("bp_we", sum_c_we, 1);
    chk("bp_din", sum_c_din, 120);
    wait_idle();
    mem[0] = 32'h7FFFFFFF; mem[1] = 1;
    run(2, 32'h80000000, 2);
    mem[0] = -5; mem[1] = 3;
    run(2, 32'hFFFFFFFE, 2);
    mem[0] = 0; mem[1] = 1;
    sb.push_back(120);
    w0 = writes;
    pulse_req(16);
    for (int k = 0; k < 5; k++) begin
      repeat (6) @(posedge clk);
      #1 sum_req = 1;
      @(posedge clk);
      #1 sum_req = 0;
    end
    wait_idle();
    repeat (10) @(posedge clk);
    #1 chk("retrig_writes", writes, w0 + 1);
    w0 = writes;
    pulse_req(16);
    repeat (10) @(posedge clk);
    #1 reset = 0;
    #1 chk("abort_busy", sum_busy, 0);
    chk("abort_outs", {sum_c_we, sum_s_oe_b}, 0);
    @(posedge clk);
    #1 reset = 1;
    repeat (60) @(posedge clk);
    #1 chk("abort_no_write", writes, w0);
    run(16, 120, 16);
    chk("sb_empty", sb.size(), 0);
    chk("stray", stray, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
